// File: rtl/memory_sequence_player_pkg.sv
// Shared types and constants for the LED memory game blocks.
// Holds the round state enum, position width, difficulty type and LFSR taps.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        SHOW_ON,
        SHOW_OFF,
        DONE
    } state_t;

    localparam int POS_W = 4;

    typedef logic [1:0] difficulty_t;

    // Galois right-shift mask for x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/memory_sequence_player_if.sv
// Bundle between game controller / checker and the sequence player.
// master: drives start, difficulty; slave: drives led, busy, seq_*.
interface memory_sequence_player_if
    import game_pkg::*;
#(
    parameter int NUM_LEDS = 10,
    parameter int MAX_LEN  = 6
);
    logic                       start;
    difficulty_t                difficulty;
    logic [NUM_LEDS-1:0]        led;
    logic                       busy;
    logic                       seq_valid;
    logic [2:0]                 seq_len;
    logic [POS_W*MAX_LEN-1:0]   seq_data;

    modport master (
        output start, difficulty,
        input  led, busy, seq_valid, seq_len, seq_data
    );

    modport slave (
        input  start, difficulty,
        output led, busy, seq_valid, seq_len, seq_data
    );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, free-running every cycle; reloads seed on reset.
// Ports: clk, reset (sync, high), seed (reset value), q (current state).
module lfsr16
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);
    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = q_q >> 1;
        if (q_q[0]) begin
            q_d = q_d ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/memory_sequence_player.sv
// Generates a random LED sequence sized by difficulty, flashes it,
// then publishes it. Ports: clk, reset (sync, high), bus (slave side).
module memory_sequence_player
    import game_pkg::*;
#(
    parameter int          NUM_LEDS   = 10,
    parameter int          BASE_LEN   = 3,
    parameter int          MAX_LEN    = 6,
    parameter int          ON_CYCLES  = 25000000,
    parameter int          OFF_CYCLES = 12500000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input logic                     clk,
    input logic                     reset,
    memory_sequence_player_if.slave bus
);
    localparam logic [NUM_LEDS-1:0] LED_ONE = NUM_LEDS'(1);
    localparam logic [3:0]          NUM_C   = 4'(NUM_LEDS);

    state_t                   state_q, state_d;
    difficulty_t              lvl_q, lvl_d;
    logic [2:0]               idx_q, idx_d;
    logic [2:0]               len_q, len_d;
    logic [31:0]              timer_q, timer_d;
    logic [POS_W*MAX_LEN-1:0] data_q, data_d;
    logic [NUM_LEDS-1:0]      led_q, led_d;

    logic [15:0]      rnd;
    logic [3:0]       cand;
    logic             lfsr_unused;
    logic [31:0]      on_ticks;
    logic [POS_W-1:0] show_pos;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (rnd)
    );

    assign cand        = rnd[3:0];
    assign lfsr_unused = ^rnd[15:4];
    assign on_ticks    = (32'(ON_CYCLES) >> lvl_q) - 32'd1;

    always_comb begin
        state_d  = state_q;
        lvl_d    = lvl_q;
        idx_d    = idx_q;
        len_d    = len_q;
        timer_d  = timer_q;
        data_d   = data_q;
        led_d    = '0;
        show_pos = '0;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    lvl_d   = bus.difficulty;
                    len_d   = 3'(BASE_LEN) + {1'b0, bus.difficulty};
                    data_d  = '0;
                    idx_d   = '0;
                    state_d = GEN;
                end
            end
            GEN: begin
                // out-of-range candidates are dropped; retry next cycle
                if (cand < NUM_C) begin
                    data_d[idx_q*POS_W +: POS_W] = cand;
                    if (idx_q + 3'd1 == len_q) begin
                        idx_d   = '0;
                        timer_d = on_ticks;
                        state_d = SHOW_ON;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            SHOW_ON: begin
                if (timer_q == 32'd0) begin
                    timer_d = 32'(OFF_CYCLES) - 32'd1;
                    state_d = SHOW_OFF;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            SHOW_OFF: begin
                if (timer_q == 32'd0) begin
                    if (idx_q == len_q - 3'd1) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        timer_d = on_ticks;
                        state_d = SHOW_ON;
                    end
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // led register follows the next state so it lines up with SHOW_ON
        show_pos = data_d[idx_d*POS_W +: POS_W];
        if (state_d == SHOW_ON) begin
            led_d = LED_ONE << show_pos;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lvl_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            timer_q <= '0;
            data_q  <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            led_q   <= led_d;
        end
    end

    assign bus.led       = led_q;
    assign bus.busy      = (state_q == GEN) || (state_q == SHOW_ON)
                         || (state_q == SHOW_OFF);
    assign bus.seq_valid = (state_q == DONE);
    assign bus.seq_len   = len_q;
    assign bus.seq_data  = data_q;
endmodule

// File: tb/tb_memory_sequence_player.sv
// Testbench for memory_sequence_player with short on/off times.
// Predicts each sequence from the seed and the start cycle.
module tb_memory_sequence_player;
    localparam int          ON   = 8;
    localparam int          OFF  = 4;
    localparam int          NL   = 10;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk;
    logic reset;

    memory_sequence_player_if #(.NUM_LEDS(NL), .MAX_LEN(6)) bus ();

    memory_sequence_player #(
        .NUM_LEDS(NL), .BASE_LEN(3), .MAX_LEN(6),
        .ON_CYCLES(ON), .OFF_CYCLES(OFF), .LFSR_SEED(SEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference random source: polynomial x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    logic [15:0] m;
    always @(posedge clk) m <= reset ? SEED : lfsr_next(m);

    logic [15:0] snap;
    int mexp[6];

    // Expected sequence: accept each 4-bit draw below NL, in order
    function automatic void model_seq(input logic [15:0] s, input int len);
        logic [15:0] v;
        int n;
        v = s;
        n = 0;
        for (int k = 0; k < 6; k++) mexp[k] = 0;
        while (n < len) begin
            if (int'(v[3:0]) < NL) begin
                mexp[n] = int'(v[3:0]);
                n++;
            end
            v = lfsr_next(v);
        end
    endfunction

    function automatic int entry(input int i);
        logic [23:0] d;
        d = bus.seq_data;
        return int'(d[4*i +: 4]);
    endfunction

    function automatic int idx_of(input logic [NL-1:0] l);
        for (int i = 0; i < NL; i++) if (l[i]) return i;
        return -1;
    endfunction

    int fpos[$];
    int fon[$];
    int fgap[$];
    bit multi;
    bit tmo;
    bit poked;

    task automatic do_start(input int lvl);
        @(negedge clk);
        bus.start = 1'b1;
        bus.difficulty = 2'(lvl);
        @(posedge clk);
        #1;
        snap = m;
        bus.start = 1'b0;
        model_seq(snap, 3 + lvl);
    endtask

    task automatic collect(input bit poke);
        int  prev_on;
        int  gap;
        bit  seen;
        int  cyc;
        prev_on = 0;
        gap = 0;
        seen = 0;
        cyc = 0;
        fpos.delete();
        fon.delete();
        fgap.delete();
        multi = 0;
        tmo = 0;
        poked = 0;
        while (1) begin
            @(negedge clk);
            if (bus.start) bus.start = 1'b0;
            if (bus.seq_valid) break;
            cyc++;
            if (cyc > 3000) begin
                tmo = 1;
                break;
            end
            if (bus.led != '0) begin
                if (!$onehot(bus.led)) multi = 1;
                if (prev_on == 0) begin
                    if (seen) fgap.push_back(gap);
                    fpos.push_back(idx_of(bus.led));
                    fon.push_back(0);
                    seen = 1;
                end
                fon[fon.size()-1] = fon[fon.size()-1] + 1;
                prev_on = 1;
                gap = 0;
                if (poke && !poked && fpos.size() == 1 && fon[0] == 3) begin
                    bus.start = 1'b1;
                    bus.difficulty = 2'd3;
                    poked = 1;
                end
            end else begin
                prev_on = 0;
                gap++;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.led !== '0) begin
            errors++;
            $display("FAIL reset_led got=%h want=0", bus.led);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got=%b want=0", bus.busy);
        end
        checks++;
        if (bus.seq_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got=%b want=0", bus.seq_valid);
        end
        checks++;
        if (bus.seq_len !== 3'd0) begin
            errors++;
            $display("FAIL reset_len got=%0d want=0", bus.seq_len);
        end
        checks++;
        if (bus.seq_data !== '0) begin
            errors++;
            $display("FAIL reset_data got=%h want=0", bus.seq_data);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Common post-round checks against the model and timing rules
    task automatic check_round(input string nm, input int lvl);
        int n;
        n = 3 + lvl;
        checks++;
        if (tmo !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout got=%b want=0", nm, tmo);
        end
        checks++;
        if (fpos.size() != n) begin
            errors++;
            $display("FAIL %s_flashes got=%0d want=%0d", nm, fpos.size(), n);
        end
        checks++;
        if (bus.seq_len !== 3'(n)) begin
            errors++;
            $display("FAIL %s_len got=%0d want=%0d", nm, bus.seq_len, n);
        end
        checks++;
        if (multi !== 1'b0) begin
            errors++;
            $display("FAIL %s_multihot got=%b want=0", nm, multi);
        end
        for (int i = 0; i < fpos.size() && i < n; i++) begin
            checks++;
            if (fpos[i] != mexp[i] || fpos[i] >= NL) begin
                errors++;
                $display("FAIL %s_pos%0d got=%0d want=%0d", nm, i, fpos[i], mexp[i]);
            end
            checks++;
            if (entry(i) != mexp[i]) begin
                errors++;
                $display("FAIL %s_data%0d got=%0d want=%0d", nm, i, entry(i), mexp[i]);
            end
            checks++;
            if (fon[i] != (ON >> lvl)) begin
                errors++;
                $display("FAIL %s_on%0d got=%0d want=%0d", nm, i, fon[i], ON >> lvl);
            end
        end
        foreach (fgap[i]) begin
            checks++;
            if (fgap[i] != OFF) begin
                errors++;
                $display("FAIL %s_gap%0d got=%0d want=%0d", nm, i, fgap[i], OFF);
            end
        end
        for (int i = n; i < 6; i++) begin
            checks++;
            if (entry(i) != 0) begin
                errors++;
                $display("FAIL %s_unused%0d got=%0d want=0", nm, i, entry(i));
            end
        end
    endtask

    task automatic test_diff0();
        do_start(0);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL d0_busy got=%b want=1", bus.busy);
        end
        collect(0);
        checks++;
        if (bus.seq_valid !== 1'b1) begin
            errors++;
            $display("FAIL d0_valid got=%b want=1", bus.seq_valid);
        end
        check_round("d0", 0);
    endtask

    task automatic test_diff3();
        do_start(3);
        collect(0);
        check_round("d3", 3);
    endtask

    task automatic test_ignored();
        do_start(0);
        collect(1);
        bus.difficulty = 2'd0;
        checks++;
        if (poked !== 1'b1) begin
            errors++;
            $display("FAIL ign_poked got=%b want=1", poked);
        end
        check_round("ign", 0);
    endtask

    task automatic test_mid_reset();
        int  nfl;
        bit  hit;
        logic [NL-1:0] prev;
        do_start(0);
        nfl = 0;
        hit = 0;
        prev = '0;
        for (int c = 0; c < 3000 && !hit; c++) begin
            @(negedge clk);
            if (bus.led != '0 && prev == '0) nfl++;
            if (nfl == 2 && bus.led == '0 && prev != '0) hit = 1;
            prev = bus.led;
        end
        checks++;
        if (hit !== 1'b1) begin
            errors++;
            $display("FAIL mr_reach got=%b want=1", hit);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.led !== '0 || bus.busy !== 1'b0 || bus.seq_valid !== 1'b0) begin
            errors++;
            $display("FAIL mr_state led=%h busy=%b valid=%b want=0/0/0",
                     bus.led, bus.busy, bus.seq_valid);
        end
        checks++;
        if (bus.seq_len !== 3'd0 || bus.seq_data !== '0) begin
            errors++;
            $display("FAIL mr_clear len=%0d data=%h want=0/0", bus.seq_len, bus.seq_data);
        end
        @(negedge clk);
        reset = 1'b0;
        do_start(1);
        collect(0);
        check_round("mr", 1);
    endtask

    task automatic test_back_to_back();
        int lvl;
        for (int r = 0; r < 20; r++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            lvl = int'($urandom_range(0, 3));
            do_start(lvl);
            checks++;
            if (bus.seq_valid !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b%0d_restart valid=%b busy=%b want=0/1",
                         r, bus.seq_valid, bus.busy);
            end
            collect(0);
            check_round($sformatf("b2b%0d", r), lvl);
        end
    endtask

    task automatic test_determinism();
        logic [23:0] run[2];
        logic [23:0] want;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
            repeat (7) @(negedge clk);
            do_start(2);
            collect(0);
            run[k] = bus.seq_data;
        end
        want = '0;
        for (int i = 0; i < 5; i++) want[4*i +: 4] = 4'(mexp[i]);
        checks++;
        if (run[1] !== run[0]) begin
            errors++;
            $display("FAIL det_repeat got=%h want=%h", run[1], run[0]);
        end
        checks++;
        if (run[0] !== want) begin
            errors++;
            $display("FAIL det_model got=%h want=%h", run[0], want);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.difficulty = 2'd0;
        test_reset();
        test_diff0();
        test_diff3();
        test_ignored();
        test_mid_reset();
        test_back_to_back();
        test_determinism();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/memory_sequence_player.md
Name: memory_sequence_player

Overview:
- Presenter side of the LED memory game: generates a pseudo-random LED-position sequence sized by difficulty, plays it on the LEDs one step at a time, then publishes it to the player-input checker.
- The checker compares switch presses against the published sequence.
- Sits between the game controller (start, difficulty) and the board LEDs/checker.

Parameters:
- NUM_LEDS, 10, number of LEDs/positions; position codes are 0..NUM_LEDS-1, and NUM_LEDS must be ≤ 15.
- BASE_LEN, 3, sequence length at difficulty 0; length = BASE_LEN + difficulty.
- MAX_LEN, 6, storage depth; must be ≥ BASE_LEN+3.
- ON_CYCLES, 25000000, LED-on time per step at difficulty 0; effective on time = ON_CYCLES >> difficulty.
- OFF_CYCLES, 12500000, dark gap between steps; independent of difficulty.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a new round when in IDLE or DONE
- difficulty  input  2  level 0..3, sampled on accepted start
- led  output  NUM_LEDS  one-hot during display, otherwise 0
- busy  output  1  high in GEN, SHOW_ON, SHOW_OFF
- seq_valid  output  1  high in DONE; sequence stable
- seq_len  output  3  current round length, 3..6
- seq_data  output  4*MAX_LEN  flattened positions; entry i is at bits [4i+3:4i]; unused entries are 0

Behaviour:
- Reset
  - state=IDLE; led=0; busy=0; seq_valid=0; seq_len=0; seq_data=0.
  - LFSR is set to LFSR_SEED; step and timer counters are set to 0.
  - Reset in any state aborts the round on the next edge.
- LFSR
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle in all states, so start timing adds entropy.
- IDLE
  - On start: latch difficulty as lvl, set seq_len=BASE_LEN+lvl, clear seq_data and idx, go to GEN.
- GEN
  - Each cycle, candidate c = LFSR[3:0].
  - If c < NUM_LEDS: write entry idx=c, then idx++. Otherwise reject and retry next cycle.
  - When idx reaches seq_len: set idx=0, load timer=(ON_CYCLES>>lvl)-1, go to SHOW_ON.
  - Worst case is unbounded in theory; the bench observes ≤ 64 cycles per entry.
- SHOW_ON
  - led = 1<<entry[idx]; timer counts down.
  - At 0: led=0, load timer=OFF_CYCLES-1, go to SHOW_OFF.
  - The LED is high for exactly ON_CYCLES>>lvl cycles.
- SHOW_OFF
  - led=0; timer counts down.
  - At 0, if idx==seq_len-1: go to DONE.
  - Otherwise: idx++, reload the on timer, go to SHOW_ON.
  - Repeated positions are therefore visible as separate flashes.
- DONE
  - seq_valid=1; seq_data and seq_len are held.
  - A start here behaves as in IDLE: seq_valid drops on the next cycle and a new round begins.
- start while busy is ignored; difficulty changes mid-round are ignored.
- Outputs are registered. led asserts on the first cycle after entering SHOW_ON.
- The sum BASE_LEN+lvl is computed at 3-bit width; maximum 6, so no overflow.

Decomposition:
- Shared package game_pkg holds:
  - state enum {IDLE, GEN, SHOW_ON, SHOW_OFF, DONE}
  - POS_W=4
  - difficulty typedef (2 bits)
  - LFSR tap constant
- The checker imports the same package.
- One sub-module: lfsr16, with ports clk, reset, seed, q. Reused by other game blocks.

Test Plan:
- Bench parameters for all scenarios: ON_CYCLES=8, OFF_CYCLES=4.
- Difficulty 0: reset, then start with difficulty=0 → busy rises; exactly 3 flashes, each 8 cycles high and 4 cycles dark; all flash positions < 10; then seq_valid=1, seq_len=3, and entries 3..5 of seq_data are 0.
- Difficulty 3: start with difficulty=3 → seq_len=6, each flash 1 cycle long, 6 flashes; the observed led one-hot positions equal seq_data entries 0..5 in order.
- Ignored inputs: pulse start and change difficulty mid-SHOW_ON → seq_len and flash count are unchanged.
- Mid-round reset: assert reset during SHOW_OFF at step 2 → next cycle led=0, busy=0, seq_valid=0, state=IDLE; a following start with difficulty=1 gives seq_len=4.
- Restart from DONE: start in DONE → seq_valid=0 on the next cycle and a new sequence is generated. Across 20 back-to-back rounds, every position is < NUM_LEDS and led is never multi-hot.
- Determinism: with fixed seed and fixed start cycle, two reset-and-start runs produce identical seq_data.
